// File: rtl/snake_pkg.sv
// Shared heading encoding and pause-FSM state type for the snake game blocks.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } pause_state_t;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO with head and tail visibility; pointers carry a wrap bit.
module dir_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       tail,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_last;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_last = wr_ptr - PTR_ONE;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign tail    = mem[wr_last[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/snake_dir_queue.sv
// Turns gamepad button levels into queued snake heading changes, applied one per step tick,
// and owns the START-toggled pause state.
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = 2'd3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  input  logic                   start,
  input  logic                   is_present,
  input  logic                   step_tick,
  output logic [1:0]             cur_dir,
  output logic                   dir_changed,
  output logic                   paused,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_full,
  output logic                   dropped
);

  logic [4:0]   btn_lvl;
  logic [4:0]   btn_prev_p0;
  logic [4:0]   btn_ev;
  pause_state_t state_q;
  pause_state_t state_d;
  logic         cand_vld;
  logic [1:0]   cand;
  logic [1:0]   ref_dir;
  logic         push;
  logic         pop;
  logic         reject;
  logic [1:0]   fifo_head;
  logic [1:0]   fifo_tail;
  logic         fifo_full;
  logic         fifo_empty;

  // Stage p0: edge detect against the previous-cycle button levels.
  assign btn_lvl = {up, down, left, right, start};
  assign btn_ev  = btn_lvl & ~btn_prev_p0;

  always_ff @(posedge clk) begin
    if (rst || !is_present) btn_prev_p0 <= '0;
    else                    btn_prev_p0 <= btn_lvl;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_PAUSE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!is_present)    state_d = ST_PAUSE;
    else if (btn_ev[0]) state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
  end

  always_comb begin
    paused = (state_q == ST_PAUSE);
  end

  // Lower-priority simultaneous presses are discarded without a dropped pulse.
  always_comb begin
    cand_vld = 1'b0;
    cand     = DIR_UP;
    if (is_present && !paused) begin
      if (btn_ev[4]) begin
        cand_vld = 1'b1;
        cand     = DIR_UP;
      end else if (btn_ev[3]) begin
        cand_vld = 1'b1;
        cand     = DIR_DOWN;
      end else if (btn_ev[2]) begin
        cand_vld = 1'b1;
        cand     = DIR_LEFT;
      end else if (btn_ev[1]) begin
        cand_vld = 1'b1;
        cand     = DIR_RIGHT;
      end
    end
  end

  // New turns are filtered against the last heading that will be in effect before them.
  assign ref_dir = fifo_empty ? cur_dir : fifo_tail;
  assign pop     = step_tick && is_present && !paused && !fifo_empty;
  assign reject  = cand_vld && ((cand == ref_dir) || (cand == opposite(ref_dir)) ||
                                (fifo_full && !pop));
  assign push    = cand_vld && !reject;

  dir_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (!is_present),
    .din   (cand),
    .dout  (fifo_head),
    .tail  (fifo_tail),
    .count (q_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign q_full = fifo_full;

  // Stage p1: applied heading and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_dir     <= INIT_DIR;
      dir_changed <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      if (pop) cur_dir <= fifo_head;
      dir_changed <= pop;
      dropped     <= reject;
    end
  end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Directed bench for snake_dir_queue with a scoreboard for dir_changed and dropped pulses.
module tb_snake_dir_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right, start, is_present, step_tick;
  logic [1:0] cur_dir;
  logic       dir_changed, paused, q_full, dropped;
  logic [2:0] q_count;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] exp_chg[$];
  int         exp_drop[$];

  localparam logic [4:0] B_UP    = 5'b10000;
  localparam logic [4:0] B_DOWN  = 5'b01000;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_START = 5'b00001;

  always #5 clk = ~clk;

  snake_dir_queue #(.DEPTH(4), .INIT_DIR(2'd3)) dut (
    .clk         (clk),
    .rst         (rst),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .start       (start),
    .is_present  (is_present),
    .step_tick   (step_tick),
    .cur_dir     (cur_dir),
    .dir_changed (dir_changed),
    .paused      (paused),
    .q_count     (q_count),
    .q_full      (q_full),
    .dropped     (dropped)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] m, input logic tk);
    {up, down, left, right, start} = m;
    step_tick = tk;
    @(negedge clk);
    {up, down, left, right, start} = 5'b0;
    step_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick();
    press(5'b0, 1'b1);
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    logic [1:0] ed;
    int         eq;
    if (dir_changed) begin
      tests++;
      if (exp_chg.size() == 0) begin
        fails++;
        $display("FAIL unexpected_dir_changed: got cur_dir=%0d expected no pulse", cur_dir);
      end else begin
        ed = exp_chg.pop_front();
        if (cur_dir !== ed) begin
          fails++;
          $display("FAIL dir_changed_value: got=%0d expected=%0d", cur_dir, ed);
        end
      end
    end
    if (dropped) begin
      tests++;
      if (exp_drop.size() == 0) begin
        fails++;
        $display("FAIL unexpected_dropped: got pulse (q_count=%0d) expected none", q_count);
      end else begin
        eq = exp_drop.pop_front();
        if (int'(q_count) != eq) begin
          fails++;
          $display("FAIL dropped_q_count: got=%0d expected=%0d", q_count, eq);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; is_present = 1'b1; step_tick = 1'b0;
    {up, down, left, right, start} = 5'b0;
    repeat (2) @(negedge clk);
    check("rst_cur_dir", cur_dir, 3);
    check("rst_paused", paused, 1);
    check("rst_q_count", q_count, 0);
    check("rst_q_full", q_full, 0);
    check("rst_dir_changed", dir_changed, 0);
    check("rst_dropped", dropped, 0);
    rst = 1'b0;

    // Unpause, repeat rejection, queue UP, apply it
    press(B_START, 1'b0);
    check("t1_unpaused", paused, 0);
    exp_drop.push_back(0);
    press(B_RIGHT, 1'b0);
    press(B_UP, 1'b0);
    check("t1_q_count", q_count, 1);
    exp_chg.push_back(2'd0);
    tick();
    check("t1_cur_dir", cur_dir, 0);
    check("t1_q_empty", q_count, 0);

    // Reversal filtering against cur_dir and against tail
    press(B_RIGHT, 1'b0);
    exp_chg.push_back(2'd3);
    tick();
    check("t2_cur_dir", cur_dir, 3);
    exp_drop.push_back(0);
    press(B_LEFT, 1'b0);
    check("t2_left_rejected", q_count, 0);
    press(B_UP, 1'b0);
    exp_drop.push_back(1);
    press(B_DOWN, 1'b0);
    check("t2_q_count", q_count, 1);

    // Fill, overflow drop, push+pop while full, drain
    press(B_LEFT, 1'b0);
    press(B_DOWN, 1'b0);
    press(B_RIGHT, 1'b0);
    check("t3_q_count_full", q_count, 4);
    check("t3_q_full", q_full, 1);
    exp_drop.push_back(4);
    press(B_UP, 1'b0);
    check("t3_after_overflow", q_count, 4);
    exp_chg.push_back(2'd0);
    press(B_UP, 1'b1);
    check("t3_pushpop_count", q_count, 4);
    check("t3_pushpop_dir", cur_dir, 0);
    check("t3_pushpop_full", q_full, 1);
    exp_chg.push_back(2'd2); exp_chg.push_back(2'd1);
    exp_chg.push_back(2'd3); exp_chg.push_back(2'd0);
    repeat (4) tick();
    check("t3_drained", q_count, 0);
    check("t3_drain_dir", cur_dir, 0);
    tick();
    check("t3_empty_tick_dir", cur_dir, 0);

    // Priority and single event for a held button
    press(B_RIGHT, 1'b0);
    exp_chg.push_back(2'd3);
    tick();
    press(B_UP | B_LEFT, 1'b0);
    check("t4_priority_count", q_count, 1);
    left = 1'b1;
    repeat (10) @(negedge clk);
    left = 1'b0;
    @(negedge clk);
    check("t4_held_count", q_count, 2);

    // Disconnect flushes and pauses; reconnect with buttons held
    press(B_DOWN, 1'b0);
    check("t5_q_count3", q_count, 3);
    is_present = 1'b0;
    @(negedge clk);
    check("t5_flushed", q_count, 0);
    check("t5_paused", paused, 1);
    check("t5_cur_dir", cur_dir, 3);
    is_present = 1'b1; down = 1'b1; start = 1'b1;
    @(negedge clk);
    check("t5_reconnect_start", paused, 0);
    check("t5_down_discarded", q_count, 0);
    repeat (3) @(negedge clk);
    down = 1'b0; start = 1'b0;
    @(negedge clk);
    check("t5_held_no_retoggle", paused, 0);
    press(B_DOWN, 1'b0);
    check("t5_down_queued", q_count, 1);

    // Paused: presses and ticks ignored; then reset mid-queue
    press(B_START, 1'b0);
    check("t6_paused", paused, 1);
    press(B_UP, 1'b0);
    check("t6_paused_press", q_count, 1);
    tick();
    check("t6_paused_tick_count", q_count, 1);
    check("t6_paused_tick_dir", cur_dir, 3);
    press(B_START, 1'b0);
    check("t6_unpause_keeps", q_count, 1);
    press(B_LEFT, 1'b0);
    check("t6_q_count2", q_count, 2);
    rst = 1'b1; up = 1'b1;
    @(negedge clk);
    check("t6_rst_cur_dir", cur_dir, 3);
    check("t6_rst_paused", paused, 1);
    check("t6_rst_q_count", q_count, 0);
    check("t6_rst_q_full", q_full, 0);
    rst = 1'b0; up = 1'b0;
    @(negedge clk);
    check("t6_rst_event_lost", q_count, 0);
    press(B_START, 1'b0);
    press(B_UP, 1'b0);
    check("t6_post_rst_push", q_count, 1);
    exp_chg.push_back(2'd0);
    tick();
    check("t6_post_rst_dir", cur_dir, 0);

    repeat (3) @(negedge clk);
    check("sb_dir_changed_outstanding", exp_chg.size(), 0);
    check("sb_dropped_outstanding", exp_drop.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
